// File: rtl/bit_reversal_stream_if.sv
// Valid/ready stream bundle for bit_reversal_stream.
// Optional out_parity exists only when BIT_REVERSAL_STREAM_PARITY_EN is defined.
interface bit_reversal_stream_if #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned CNT_W     = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_SIZE-1:0] in_data;
  logic [1:0]           in_rev_type;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_SIZE-1:0] out_data;
  logic [CNT_W-1:0]     level;
`ifdef BIT_REVERSAL_STREAM_PARITY_EN
  logic                 out_parity;

  modport master (
    output in_valid, in_data, in_rev_type, out_ready,
    input  in_ready, out_valid, out_data, level, out_parity
  );

  modport slave (
    input  in_valid, in_data, in_rev_type, out_ready,
    output in_ready, out_valid, out_data, level, out_parity
  );
`else
  modport master (
    output in_valid, in_data, in_rev_type, out_ready,
    input  in_ready, out_valid, out_data, level
  );

  modport slave (
    input  in_valid, in_data, in_rev_type, out_ready,
    output in_ready, out_valid, out_data, level
  );
`endif
endinterface

// File: rtl/bit_reversal_stream.sv
// Streaming bit-reflection unit: reflects each accepted word (identity, per-byte,
// per-halfword or full-word reversal) and buffers it in a DEPTH-entry FIFO.
// Optional feature macro: BIT_REVERSAL_STREAM_PARITY_EN stores and presents the
// XOR-reduce of each reflected word on out_parity.
module bit_reversal_stream #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned CNT_W     = 2
) (
  input  logic clk,
  input  logic rst,
  bit_reversal_stream_if.slave bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef BIT_REVERSAL_STREAM_PARITY_EN
  localparam int unsigned STORE_W = DATA_SIZE + 1;
`else
  localparam int unsigned STORE_W = DATA_SIZE;
`endif

  if (CNT_W != $clog2(DEPTH) + 1) begin : g_bad_cnt_w
    $error("CNT_W must equal log2(DEPTH)+1");
  end
  if ((DATA_SIZE < 16) || (DATA_SIZE % 16 != 0)) begin : g_bad_data_size
    $error("DATA_SIZE must be a multiple of 16, minimum 16");
  end

  logic [STORE_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0]     rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]     level_q, level_nxt;
  logic                 in_ready_q, in_ready_nxt;
  logic                 out_valid_q, out_valid_nxt;
  logic                 push, pop;
  logic [DATA_SIZE-1:0] reflected;
  logic [STORE_W-1:0]   wr_word;

  assign push = bus.in_valid & in_ready_q;
  assign pop  = out_valid_q & bus.out_ready;

  // Reflect the incoming word according to this beat's mode
  always_comb begin
    reflected = '0;
    for (int i = 0; i < int'(DATA_SIZE); i++) begin
      case (bus.in_rev_type)
        2'd1:    reflected[i] = bus.in_data[(i / 8) * 8 + 7 - (i % 8)];
        2'd2:    reflected[i] = bus.in_data[(i / 16) * 16 + 15 - (i % 16)];
        2'd3:    reflected[i] = bus.in_data[int'(DATA_SIZE) - 1 - i];
        default: reflected[i] = bus.in_data[i];
      endcase
    end
`ifdef BIT_REVERSAL_STREAM_PARITY_EN
    wr_word = {^reflected, reflected};
`else
    wr_word = reflected;
`endif
  end

  // Next pointer/level and flag values from this cycle's push/pop
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    level_nxt  = level_q;
    if (push) wr_ptr_nxt = wr_ptr + PTR_W'(1);
    if (pop)  rd_ptr_nxt = rd_ptr + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_nxt = level_q + CNT_W'(1);
      2'b01:   level_nxt = level_q - CNT_W'(1);
      default: level_nxt = level_q;
    endcase
    in_ready_nxt  = (level_nxt != CNT_W'(DEPTH));
    out_valid_nxt = (level_nxt != '0);
  end

  // Control state: pointers, level and the handshake flags derived from it
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      level_q     <= level_nxt;
      in_ready_q  <= in_ready_nxt;
      out_valid_q <= out_valid_nxt;
    end
  end

  // Storage write; contents are not reset and a beat during reset is dropped
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.level     = level_q;
  assign bus.out_data  = mem[rd_ptr][DATA_SIZE-1:0];
`ifdef BIT_REVERSAL_STREAM_PARITY_EN
  assign bus.out_parity = mem[rd_ptr][DATA_SIZE];
`endif

endmodule

// File: tb/tb_bit_reversal_stream.sv
// Self-checking bench for bit_reversal_stream (DATA_SIZE=32, DEPTH=4).
module tb_bit_reversal_stream;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  bit   last_push;
  logic [DW-1:0] exp_q [$];

  bit_reversal_stream_if #(.DATA_SIZE(DW), .CNT_W(CW)) bus ();

  bit_reversal_stream #(.DATA_SIZE(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference reflection built from streaming operators
  function automatic logic [DW-1:0] ref_reflect(input logic [DW-1:0] d, input logic [1:0] t);
    logic [DW-1:0] r;
    logic [DW-1:0] o;
    r = {<<{d}};
    case (t)
      2'd0:    o = d;
      2'd1:    o = {<<8{r}};
      2'd2:    o = {<<16{r}};
      default: o = r;
    endcase
    return o;
  endfunction

  // Advance one clock and update the queue model from the driven inputs
  task automatic tick();
    bit p;
    bit q;
    logic [DW-1:0] w;
    p = !rst && bus.in_valid && (exp_q.size() < DEPTH);
    q = !rst && bus.out_ready && (exp_q.size() > 0);
    w = ref_reflect(bus.in_data, bus.in_rev_type);
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      p = 1'b0;
    end else begin
      if (q) void'(exp_q.pop_front());
      if (p) exp_q.push_back(w);
    end
    last_push = p;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = $urandom;
    bus.in_rev_type = 2'($urandom_range(0, 3));
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.level !== CW'(0)) begin n_bad++; $display("FAIL reset_level: got %0d expected 0", bus.level); end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    tick();
    n_cmp++;
    if (bus.level !== CW'(0)) begin n_bad++; $display("FAIL reset_nothing_enqueued: level %0d expected 0", bus.level); end
  endtask

  task automatic test_modes();
    logic [DW-1:0] exp_tab [4];
    exp_tab = '{32'h1a2b3c4d, 32'h58d43cb2, 32'hd458b23c, 32'hb23cd458};
    bus.out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 32'h1a2b3c4d;
      bus.in_rev_type = 2'(t);
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_tab[t])
        begin n_bad++; $display("FAIL mode_%0d: got v=%b %h expected v=1 %h", t, bus.out_valid, bus.out_data, exp_tab[t]); end
    end
    bus.in_valid = 1'b0;
    tick();
    n_cmp++;
    if (bus.level !== CW'(0) || bus.out_valid !== 1'b0)
      begin n_bad++; $display("FAIL mode_drain: level %0d valid %b expected 0 0", bus.level, bus.out_valid); end
  endtask

  task automatic test_backpressure();
    bit accepted;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = $urandom;
      bus.in_rev_type = 2'($urandom_range(0, 3));
      n_cmp++;
      if (bus.in_ready !== (i < 4))
        begin n_bad++; $display("FAIL bp_in_ready_%0d: got %b expected %b", i, bus.in_ready, (i < 4)); end
      tick();
    end
    n_cmp++;
    if (bus.level !== CW'(4) || bus.in_ready !== 1'b0)
      begin n_bad++; $display("FAIL bp_full: level %0d ready %b expected 4 0", bus.level, bus.in_ready); end
    bus.out_ready = 1'b1;
    accepted = 1'b0;
    for (int c = 0; c < 20 && !(accepted && exp_q.size() == 0); c++) begin
      n_cmp++;
      if (bus.out_valid !== (exp_q.size() != 0))
        begin n_bad++; $display("FAIL bp_out_valid: got %b expected %b", bus.out_valid, (exp_q.size() != 0)); end
      if (exp_q.size() != 0) begin
        n_cmp++;
        if (bus.out_data !== exp_q[0])
          begin n_bad++; $display("FAIL bp_order: got %h expected %h", bus.out_data, exp_q[0]); end
      end
      tick();
      if (last_push) begin
        accepted = 1'b1;
        bus.in_valid = 1'b0;
      end
    end
    n_cmp++;
    if (!(accepted && exp_q.size() == 0) || bus.out_valid !== 1'b0)
      begin n_bad++; $display("FAIL bp_drain_timeout: accepted %b left %0d valid %b", accepted, exp_q.size(), bus.out_valid); end
  endtask

  task automatic test_simultaneous();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = $urandom;
      bus.in_rev_type = 2'($urandom_range(0, 3));
      tick();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_data = $urandom;
      bus.in_rev_type = 2'($urandom_range(0, 3));
      n_cmp++;
      if (bus.level !== CW'(2) || exp_q.size() == 0 || bus.out_data !== exp_q[0])
        begin n_bad++; $display("FAIL simul_%0d: level %0d data %h expected 2 %h", i, bus.level, bus.out_data, (exp_q.size() != 0) ? exp_q[0] : '0); end
      tick();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (exp_q.size() == 0 || bus.out_data !== exp_q[0])
        begin n_bad++; $display("FAIL simul_tail_%0d: got %h", i, bus.out_data); end
      tick();
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL simul_empty: valid %b expected 0", bus.out_valid); end
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] w;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = $urandom;
      bus.in_rev_type = 2'($urandom_range(0, 3));
      tick();
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.level !== CW'(3)) begin n_bad++; $display("FAIL midrst_fill: level %0d expected 3", bus.level); end
    rst = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.level !== CW'(0) || bus.out_valid !== 1'b0)
      begin n_bad++; $display("FAIL midrst_clear: level %0d valid %b expected 0 0", bus.level, bus.out_valid); end
    w = $urandom;
    bus.in_valid = 1'b1;
    bus.in_data = w;
    bus.in_rev_type = 2'd0;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== w)
      begin n_bad++; $display("FAIL midrst_first: got v=%b %h expected v=1 %h", bus.out_valid, bus.out_data, w); end
    bus.out_ready = 1'b1;
    tick();
    n_cmp++;
    if (bus.level !== CW'(0)) begin n_bad++; $display("FAIL midrst_pop: level %0d expected 0", bus.level); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_data = $urandom;
      bus.in_rev_type = 2'($urandom_range(0, 3));
      n_cmp++;
      if (bus.level !== CW'(exp_q.size()) || bus.in_ready !== (exp_q.size() != DEPTH) ||
          bus.out_valid !== (exp_q.size() != 0))
        begin n_bad++; $display("FAIL rand_flags_%0d: level %0d ready %b valid %b expected level %0d", c, bus.level, bus.in_ready, bus.out_valid, exp_q.size()); end
      if (exp_q.size() != 0) begin
        n_cmp++;
        if (bus.out_data !== exp_q[0])
          begin n_bad++; $display("FAIL rand_data_%0d: got %h expected %h", c, bus.out_data, exp_q[0]); end
`ifdef BIT_REVERSAL_STREAM_PARITY_EN
        n_cmp++;
        if (bus.out_parity !== ^exp_q[0])
          begin n_bad++; $display("FAIL rand_parity_%0d: got %b expected %b", c, bus.out_parity, ^exp_q[0]); end
`endif
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) tick();
  endtask

`ifdef BIT_REVERSAL_STREAM_PARITY_EN
  task automatic test_parity();
    logic [DW-1:0] words [2];
    logic          exp_par [2];
    words = '{32'h1a2b3c4d, 32'h00000003};
    exp_par = '{1'b1, 1'b0};
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = words[i];
      bus.in_rev_type = 2'($urandom_range(0, 3));
      tick();
      bus.in_valid = 1'b0;
      n_cmp++;
      if (bus.out_parity !== exp_par[i])
        begin n_bad++; $display("FAIL parity_%0d: got %b expected %b", i, bus.out_parity, exp_par[i]); end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    last_push = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_rev_type = 2'd0;
    bus.out_ready = 1'b0;
    #1;
    test_reset();
    test_modes();
    test_backpressure();
    test_simultaneous();
    test_mid_reset();
    test_random();
`ifdef BIT_REVERSAL_STREAM_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bit_reversal_stream.md
Name: bit_reversal_stream

Overview:
- Streaming, parametrised successor to the combinational bit-reversal unit used on the CRC data path (REV_IN/REV_OUT reflection).
- Applies a per-beat reflection mode to each input word and buffers the result in a DEPTH-entry FIFO.
- Uses valid/ready handshakes on both sides, so it sits between the bus-side data register and the CRC engine and absorbs engine backpressure.

Parameters:
- DATA_SIZE, 32, data width in bits; multiple of 16, minimum 16.
- DEPTH, 2, FIFO entries; power of 2, minimum 2.
- CNT_W, 2, width of the level output; must equal log2(DEPTH)+1.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept a beat.
- in_data  input  DATA_SIZE  word to reflect.
- in_rev_type  input  2  reflection mode for this beat.
- out_valid  output  1  output beat present.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  DATA_SIZE  reflected word.
- level  output  CNT_W  number of occupied entries.
- out_parity  output  1  only with BIT_REVERSAL_STREAM_PARITY_EN; XOR of out_data.

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: level=0, out_valid=0, in_ready=1, read/write pointers=0. FIFO storage is not reset; out_data is don't-care while out_valid=0.
- Reflection is applied combinationally on in_data at write time; the FIFO stores reflected words and the mode is not stored.
  - rev_type 0: identity.
  - rev_type 1: reverse bit order within each byte.
  - rev_type 2: reverse bit order within each 16-bit halfword.
  - rev_type 3: reverse the entire DATA_SIZE word.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (level != DEPTH), registered-equivalent: derived from the level register only, with no combinational path from out_ready.
- out_valid = (level != 0), derived from the level register only.
- out_data = entry at the read pointer, driven from the storage array; out_parity has the same timing.
- Latency: a word pushed at edge N appears on out_data/out_valid after edge N; there is no same-cycle bypass.
- Level update:
  - push only: level+1.
  - pop only: level-1.
  - push and pop together: level unchanged, both pointers advance.
- Full (level=DEPTH): in_ready=0, so no push; a pop that cycle makes in_ready=1 the next cycle.
- Empty (level=0): out_valid=0, so no pop; a push that cycle makes out_valid=1 the next cycle.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Stability: once out_valid=1, out_data is held until popped; the order of pushed words is preserved.
- Reset mid-operation: all buffered words are discarded; level=0 and out_valid=0 on the cycle after the rst edge; any in_valid during rst is ignored.
- in_rev_type is sampled only on push cycles; changes while in_valid=0 have no effect.

Optional Feature:
- Macro: BIT_REVERSAL_STREAM_PARITY_EN.
- With the macro defined:
  - Storage width becomes DATA_SIZE+1; bit DATA_SIZE holds the XOR-reduce of the reflected word, computed at write.
  - out_parity presents the stored bit alongside out_data.
- Without the macro: the out_parity port and the extra storage bit do not exist. Data path behaviour is otherwise identical.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 -> level=0, out_valid=0, in_ready=1; nothing is enqueued.
- Mode sweep (DATA_SIZE=32): push 32'h1a2b3c4d with rev_type 0,1,2,3 on consecutive cycles while out_ready=1 -> out_data sequence 1a2b3c4d, 58d43cb2, d458b23c, b23cd458, each one cycle after its push.
- Backpressure (DEPTH=4): out_ready=0, push 5 beats on 5 consecutive cycles -> in_ready drops after the 4th push, level=4, 5th beat is held. Then assert out_ready=1 -> 4 beats drain in order, and the 5th is accepted once in_ready returns to 1.
- Simultaneous push/pop at level=2 for 10 cycles -> level stays 2, output order equals input order, and pointers wrap correctly.
- Reset mid-stream with level=3 -> next cycle level=0, out_valid=0; the first push after reset is the first word output.
- Parity (macro defined): push 32'h1a2b3c4d with any rev_type -> out_parity=1. Push 32'h00000003 -> out_parity=0.
